// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the backing-store memory model.
//   WORD_W          - data word width of the memory port
//   DEFAULT_LATENCY - default access latency in cycles
//   CNT_W           - width of the latency down-counter (covers 1..255)
//   state_t         - request FSM states
package ram_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_LATENCY = 4;
    localparam int CNT_W           = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage : ram_pkg

// File: rtl/ram_word_array.sv
// ram_word_array: single-port word array, synchronous write, combinational read.
// Contents start at zero at time zero and are never cleared afterwards.
//   clk   - clock
//   we    - write enable, write happens on posedge
//   idx   - word index (read and write share it)
//   wdata - write data
//   rdata - combinational read data at idx
module ram_word_array
    import ram_pkg::*;
#(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] idx,
    input  logic [WORD_W-1:0]    wdata,
    output logic [WORD_W-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule : ram_word_array

// File: rtl/ram_backing_store.sv
// ram_backing_store: responder end of the cache memory port.
// A new request is any clock edge at which {data, addr, wr} differs from the
// copy latched for the previous request. The request is held for LATENCY
// cycles with response low, then the write is committed or the read word is
// returned and response rises. Changing inputs mid-flight aborts and restarts.
//   clk      - clock
//   rst      - synchronous active-high reset (memory contents survive it)
//   data     - write data
//   addr     - word address, only addr[ADDR_BITS-1:0] selects a word
//   wr       - 1 = write, 0 = read
//   response - 1 = idle / last request complete, 0 = request in flight
//   out      - read data of the last completed read
//   rd_count - completed reads since reset (wraps)
//   wr_count - completed writes since reset (wraps)
module ram_backing_store
    import ram_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data,
    input  logic [31:0]       addr,
    input  logic              wr,
    output logic              response,
    output logic [WORD_W-1:0] out,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [WORD_W-1:0] lat_data;
    logic [31:0]       lat_addr;
    logic              lat_wr;
    logic [CNT_W-1:0]  cnt;

    logic              req_edge;
    logic              complete;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // Full-width compare: upper address bits still count as a new request
    // even though they alias onto the same word.
    assign req_edge = ({data, addr, wr} != {lat_data, lat_addr, lat_wr});
    assign complete = (state == BUSY) && !req_edge && (cnt == '0);
    // Reset blocks the commit so an aborted write never lands.
    assign mem_we   = complete && lat_wr && !rst;

    ram_word_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (lat_addr[ADDR_BITS-1:0]),
        .wdata (lat_data),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            response <= 1'b1;
            out      <= '0;
            rd_count <= '0;
            wr_count <= '0;
            lat_data <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        lat_data <= data;
                        lat_addr <= addr;
                        lat_wr   <= wr;
                        cnt      <= CNT_LOAD;
                        response <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (req_edge) begin
                        // Abort and restart the latency window for the new request.
                        lat_data <= data;
                        lat_addr <= addr;
                        lat_wr   <= wr;
                        cnt      <= CNT_LOAD;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state    <= IDLE;
                        response <= 1'b1;
                        if (lat_wr) begin
                            wr_count <= wr_count + 1'b1;
                        end else begin
                            out      <= mem_rdata;
                            rd_count <= rd_count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : ram_backing_store

// File: tb/tb_ram_backing_store.sv
// Directed bench for ram_backing_store with LATENCY=4.
module tb_ram_backing_store;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [31:0] addr;
    logic        wr;
    logic        response;
    logic [31:0] out;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int n_assert = 0;
    int n_fail   = 0;

    ram_backing_store #(
        .ADDR_BITS (10),
        .LATENCY   (LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .addr     (addr),
        .wr       (wr),
        .response (response),
        .out      (out),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request and walk it to completion: response low on the
    // request edge and the following LAT-1 edges, high on edge N+LAT.
    task automatic request(input string tag, input logic [31:0] d,
                           input logic [31:0] a, input logic w);
        data = d;
        addr = a;
        wr   = w;
        for (int i = 0; i < LAT; i++) begin
            step();
            check({tag, "_busy"}, {31'd0, response}, 32'd0);
        end
        step();
        check({tag, "_done"}, {31'd0, response}, 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        data = '0;
        addr = '0;
        wr   = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state and idle with all-zero inputs.
        check("rst_response", {31'd0, response}, 32'd1);
        check("rst_out", out, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("idle_response", {31'd0, response}, 32'd1);
        check("idle_out", out, 32'd0);
        check("idle_rd_count", rd_count, 32'd0);
        check("idle_wr_count", wr_count, 32'd0);

        // Write then read back addr 5.
        request("wr5", 32'hDEADBEEF, 32'd5, 1'b1);
        check("wr5_wr_count", wr_count, 32'd1);
        check("wr5_out_unchanged", out, 32'd0);
        request("rd5", 32'd0, 32'd5, 1'b0);
        check("rd5_out", out, 32'hDEADBEEF);
        check("rd5_rd_count", rd_count, 32'd1);

        // Abort write to 7 by switching to 8 before edge N+2.
        data = 32'h11;
        addr = 32'd7;
        wr   = 1'b1;
        step();
        check("abort_n0", {31'd0, response}, 32'd0);
        step();
        check("abort_n1", {31'd0, response}, 32'd0);
        request("wr8", 32'h11, 32'd8, 1'b1);
        check("wr8_wr_count", wr_count, 32'd2);
        request("rd7", 32'd0, 32'd7, 1'b0);
        check("rd7_out", out, 32'd0);
        request("rd8", 32'd0, 32'd8, 1'b0);
        check("rd8_out", out, 32'h11);
        check("rd8_rd_count", rd_count, 32'd3);

        // Upper address bits alias onto the same word.
        request("wr3", 32'hA5A5A5A5, 32'd3, 1'b1);
        request("rd_alias3", 32'd0, (32'd1 << 10) + 32'd3, 1'b0);
        check("alias_out", out, 32'hA5A5A5A5);
        check("alias_rd_count", rd_count, 32'd4);
        check("alias_wr_count", wr_count, 32'd3);

        // Reset during an in-flight write to 9 aborts the write.
        data = 32'h55;
        addr = 32'd9;
        wr   = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        check("rstmid_response", {31'd0, response}, 32'd1);
        check("rstmid_rd_count", rd_count, 32'd0);
        check("rstmid_wr_count", wr_count, 32'd0);
        check("rstmid_out", out, 32'd0);
        // Read request held through reset is ignored, then seen after release.
        data = 32'd0;
        addr = 32'd9;
        wr   = 1'b0;
        step();
        check("rst_wins_response", {31'd0, response}, 32'd1);
        rst = 1'b0;
        request("rd9", 32'd0, 32'd9, 1'b0);
        check("rd9_out", out, 32'd0);
        check("rd9_rd_count", rd_count, 32'd1);
        check("rd9_wr_count", wr_count, 32'd0);

        // Preload 1 and 2, reset (memory survives), then back-to-back reads.
        request("wr1", 32'h1, 32'd1, 1'b1);
        request("wr2", 32'h2, 32'd2, 1'b1);
        data = '0;
        addr = '0;
        wr   = 1'b0;
        rst  = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_wr_count", wr_count, 32'd0);
        request("rd1", 32'd0, 32'd1, 1'b0);
        check("rd1_out", out, 32'h1);
        request("rd2", 32'd0, 32'd2, 1'b0);
        check("rd2_out", out, 32'h2);
        check("b2b_rd_count", rd_count, 32'd2);

        // Stable inputs after completion start nothing new.
        for (int i = 0; i < 3; i++) step();
        check("hold_response", {31'd0, response}, 32'd1);
        check("hold_rd_count", rd_count, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_ram_backing_store
